// File: rtl/depacketizer_pkg.sv
// Shared types and widths for the pol A/B depacketizer.
package depacketizer_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 64;
  localparam int unsigned SUBWORDS = 4;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {HDR, A, B, DROP} rx_state_t;
  typedef enum logic {IDLE, PLAY} pb_state_t;

  // Saturating +1 for the error counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Sample lane s of a word, lane 3 is the MSB sample
  function automatic logic [SAMPLE_W-1:0] lane(input logic [WORD_W-1:0] w, input logic [1:0] s);
    unique case (s)
      2'd3:    lane = w[63:48];
      2'd2:    lane = w[47:32];
      2'd1:    lane = w[31:16];
      default: lane = w[15:0];
    endcase
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
module sdp_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/depacketizer.sv
// Receives framed pol A/B packets into ping-pong banks and replays them as
// 16-bit sample pairs, counting framing, sequence and overflow errors.
module depacketizer
  import depacketizer_pkg::*;
#(
  parameter int unsigned WORDS = 512,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic [WORD_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic                rx_eod,
  output logic [SAMPLE_W-1:0] pol_a,
  output logic [SAMPLE_W-1:0] pol_b,
  output logic                out_valid,
  output logic                sync,
  output logic [WORD_W-1:0]   payload_id,
  output logic [CNT_W-1:0]    len_err_cnt,
  output logic [CNT_W-1:0]    seq_err_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  rx_state_t         rx_state, rx_next;
  logic [AW-1:0]     wcnt, wcnt_next;
  logic              wbank;
  logic [1:0]        full;
  logic [WORD_W-1:0] hdr [2];
  logic [WORD_W-1:0] prev_id;
  logic              prev_vld;
  logic we_a_c, we_b_c, hdr_we_c, set_full_c, len_inc_c, drop_inc_c, seq_inc_c;

  pb_state_t         pb_state, pb_next;
  logic [AW-1:0]     r, r_next;
  logic [1:0]        s, s_next;
  logic              rbank, rbank_next;
  logic              clr_full_c, sel_c, first_c;

  logic              s1_vld, s1_first, s1_bank;
  logic [1:0]        s1_s;
  logic [WORD_W-1:0] rd_a [2];
  logic [WORD_W-1:0] rd_b [2];

  // RX framing: next state and write strobes
  always_comb begin
    rx_next    = rx_state;
    wcnt_next  = wcnt;
    we_a_c     = 1'b0;
    we_b_c     = 1'b0;
    hdr_we_c   = 1'b0;
    set_full_c = 1'b0;
    len_inc_c  = 1'b0;
    drop_inc_c = 1'b0;
    if (rx_valid) begin
      unique case (rx_state)
        HDR: begin
          if (rx_eod) begin
            len_inc_c = 1'b1;
          end else if (full[wbank]) begin
            drop_inc_c = 1'b1;
            rx_next    = DROP;
          end else begin
            hdr_we_c  = 1'b1;
            wcnt_next = '0;
            rx_next   = A;
          end
        end
        A: begin
          we_a_c = 1'b1;
          if (rx_eod) begin
            len_inc_c = 1'b1;
            rx_next   = HDR;
          end else if (wcnt == LAST) begin
            wcnt_next = '0;
            rx_next   = B;
          end else begin
            wcnt_next = wcnt + AW'(1);
          end
        end
        B: begin
          we_b_c = 1'b1;
          if (wcnt == LAST) begin
            if (rx_eod) begin
              set_full_c = 1'b1;
              rx_next    = HDR;
            end else begin
              len_inc_c = 1'b1;
              rx_next   = DROP;
            end
          end else if (rx_eod) begin
            len_inc_c = 1'b1;
            rx_next   = HDR;
          end else begin
            wcnt_next = wcnt + AW'(1);
          end
        end
        DROP: if (rx_eod) rx_next = HDR;
        default: rx_next = HDR;
      endcase
    end
  end

  assign seq_inc_c = set_full_c && prev_vld && (hdr[wbank] != prev_id + 64'd1);

  // Playback walk over word index r and subword s, MSB sample first
  always_comb begin
    pb_next    = pb_state;
    r_next     = r;
    s_next     = s;
    rbank_next = rbank;
    clr_full_c = 1'b0;
    sel_c      = 1'b0;
    first_c    = 1'b0;
    if (ce) begin
      unique case (pb_state)
        IDLE: if (full[rbank]) begin
          pb_next = PLAY;
          r_next  = '0;
          s_next  = 2'(SUBWORDS - 1);
        end
        PLAY: begin
          sel_c   = 1'b1;
          first_c = (r == '0) && (s == 2'(SUBWORDS - 1));
          if (s == 2'd0) begin
            s_next = 2'(SUBWORDS - 1);
            r_next = r + AW'(1);
            if (r == LAST) begin
              clr_full_c = 1'b1;
              rbank_next = ~rbank;
              r_next     = '0;
              if (!full[~rbank]) pb_next = IDLE;
            end
          end else begin
            s_next = s - 2'd1;
          end
        end
        default: pb_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= HDR;
      wcnt        <= '0;
      wbank       <= 1'b0;
      full        <= '0;
      hdr[0]      <= '0;
      hdr[1]      <= '0;
      prev_id     <= '0;
      prev_vld    <= 1'b0;
      len_err_cnt <= '0;
      seq_err_cnt <= '0;
      drop_cnt    <= '0;
      pb_state    <= IDLE;
      r           <= '0;
      s           <= '0;
      rbank       <= 1'b0;
    end else begin
      rx_state    <= rx_next;
      wcnt        <= wcnt_next;
      wbank       <= wbank ^ set_full_c;
      if (hdr_we_c) hdr[wbank] <= rx_data;
      if (set_full_c) begin
        full[wbank] <= 1'b1;
        prev_id     <= hdr[wbank];
        prev_vld    <= 1'b1;
      end
      if (clr_full_c) full[rbank] <= 1'b0;
      len_err_cnt <= sat_inc(len_err_cnt, len_inc_c);
      seq_err_cnt <= sat_inc(seq_err_cnt, seq_inc_c);
      drop_cnt    <= sat_inc(drop_cnt, drop_inc_c);
      pb_state    <= pb_next;
      r           <= r_next;
      s           <= s_next;
      rbank       <= rbank_next;
    end
  end

  // Two banks; both are read at r and the selected one is muxed downstream
  for (genvar g = 0; g < 2; g++) begin : g_bank
    sdp_ram #(.DEPTH(WORDS), .WIDTH(WORD_W)) u_ram_a (
      .clk(clk), .we(we_a_c && (wbank == 1'(g))), .waddr(wcnt), .wdata(rx_data),
      .raddr(r), .rdata(rd_a[g]));
    sdp_ram #(.DEPTH(WORDS), .WIDTH(WORD_W)) u_ram_b (
      .clk(clk), .we(we_b_c && (wbank == 1'(g))), .waddr(wcnt), .wdata(rx_data),
      .raddr(r), .rdata(rd_b[g]));
  end

  // Stage 1 tracks the RAM read; stage 2 registers the selected lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_first   <= 1'b0;
      s1_bank    <= 1'b0;
      s1_s       <= '0;
      out_valid  <= 1'b0;
      sync       <= 1'b0;
      pol_a      <= '0;
      pol_b      <= '0;
      payload_id <= '0;
    end else begin
      s1_vld    <= sel_c;
      s1_first  <= first_c;
      s1_bank   <= rbank;
      s1_s      <= s;
      out_valid <= s1_vld;
      sync      <= s1_vld && s1_first;
      if (s1_vld) begin
        pol_a <= lane(rd_a[s1_bank], s1_s);
        pol_b <= lane(rd_b[s1_bank], s1_s);
      end
      if (s1_vld && s1_first) payload_id <= hdr[s1_bank];
    end
  end

  // The bank being filled can never be the one being released
  a_no_same_bank: assert property (@(posedge clk) disable iff (!rst_n)
    !(set_full_c && clr_full_c && (wbank == rbank)));

endmodule

// File: doc/depacketizer.md
Name: depacketizer

Overview:
- Receive side of the pol A/B sample packet stream. Consumes 64-bit words (data/valid/eod) framed as: 1 header word (64-bit payload id), WORDS pol-A words, WORDS pol-B words; eod is asserted on the last pol-B word.
- Unpacks and re-pairs samples, then replays them as 16-bit pol_a/pol_b pairs, one pair per ce cycle.
- Sits at the far end of a loopback/capture path and checks framing and payload-id continuity.

Parameters:
- WORDS, 512, 64-bit words per polarisation per packet (power of two, at least 4).
- AW, $clog2(WORDS), word address width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ce  in  1  output-side sample enable.
- rx_data  in  64  stream word.
- rx_valid  in  1  rx_data qualifier; words may have gaps.
- rx_eod  in  1  end of packet; meaningful only when rx_valid is high.
- pol_a  out  16  pol A sample.
- pol_b  out  16  pol B sample.
- out_valid  out  1  pol_a/pol_b hold a new pair this cycle.
- sync  out  1  high together with the first pair of each packet.
- payload_id  out  64  header of the packet currently playing.
- len_err_cnt  out  16  count of packets with bad length (saturating).
- seq_err_cnt  out  16  count of payload-id discontinuities (saturating).
- drop_cnt  out  16  count of packets dropped because no bank was free (saturating).

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0; both banks empty; RX FSM goes to HDR; playback goes to IDLE.
- Storage: two ping-pong banks. Each bank holds an A RAM and a B RAM (WORDS x 64, 1-cycle read latency) plus a header register and a full flag.
- RX FSM (advances only on rx_valid):
  - HDR: the word is the header.
    - If rx_eod is high: len_err +1, stay in HDR.
    - Else if the write bank is full: drop +1, go to DROP.
    - Else latch the header, wcnt=0, go to A.
  - A: write to A RAM[wcnt].
    - If rx_eod is high: len_err +1, go to HDR, bank not marked full.
    - At wcnt==WORDS-1: wcnt=0, go to B.
  - B: write to B RAM[wcnt].
    - If rx_eod is high at wcnt==WORDS-1: mark the bank full, toggle the write bank, go to HDR.
    - If rx_eod is high earlier: len_err +1, go to HDR.
    - If rx_eod is low at wcnt==WORDS-1: len_err +1, go to DROP (discard the remainder).
  - DROP: discard words until rx_eod, then go to HDR.
- Sequence check: on each packet accepted into a bank (full mark), if a previous packet was accepted and header != prev+1 (mod 2^64), seq_err +1. The previous id is updated to this header whether or not an error was counted.
- Playback FSM (advances only on ce):
  - IDLE: if the read bank is full, go to PLAY, word index r=0, subword s=3.
  - PLAY: read A[r] and B[r] together. Per ce, output bits [16*s+15:16*s] of each word (MSB sample first, s = 3,2,1,0).
    - After s==0, r increments.
    - After r==WORDS-1 and s==0: clear the read bank's full flag, toggle the read bank, return to IDLE. If the other bank is already full, go straight to PLAY with no bubble.
- Output latency: out_valid is registered and occurs 2 cycles after the ce that selects the pair. The RAM read is prefetched so consecutive ce cycles give gapless pairs.
- sync and the payload_id update coincide with out_valid for the pair at r=0, s=3.
- A packet fills a bank only on correct framing; a partial packet never becomes visible.
- Same bank fully written and freed in the same cycle: cannot occur, because the write bank is always the non-reading bank once a full flag is set. The implementation must assert this.
- Error counters saturate at 16'hFFFF.
- rx_valid with ce low: RX proceeds normally; ce gates playback only.

Decomposition:
- Package depacketizer_pkg:
  - RX state enum {HDR, A, B, DROP}.
  - Playback enum {IDLE, PLAY}.
  - SAMPLE_W=16, WORD_W=64, SUBWORDS=4.
- Sub-module sdp_ram: simple dual-port RAM, parameters DEPTH and WIDTH, registered read. Instantiate 4 copies.

Test Plan:
1. One packet: header 0x5, A word k = {4k,4k+1,4k+2,4k+3}, B word k = A word k + 0x8000 per lane, eod on word 1024, ce=1.
   Required: 2048 pairs; pol_a = 0,1,2,...,2047; pol_b = pol_a + 0x8000; sync only on the first pair; payload_id=5; all counters 0.
2. Back-to-back packets with ids 7, 8, 10 and no rx gaps.
   Required: gapless playback of 6144 pairs; sync three times; seq_err_cnt=1.
3. Short packet: eod on A word 100.
   Required: len_err_cnt=1, no output. A following good packet plays normally.
4. Long packet (eod missing on the last B word, present 3 words later).
   Required: len_err_cnt=1; DROP is entered and exited; the next good packet is accepted.
5. ce held low while three packets arrive.
   Required: the first two fill the banks, the third gives drop_cnt=1. After releasing ce, exactly two packets play.
6. Assert rst_n low mid-playback and mid-RX.
   Required: outputs go to 0 immediately; the next full packet after release plays from sample 0 with no stale data.
